// File: rtl/mmram_stage_pkg.sv
// Shared widths, field positions and packet layouts for the matching-memory stage.
`timescale 1ns/1ps
package mmram_stage_pkg;

  localparam int COLOR_W     = 3;
  localparam int GEN_W       = 8;
  localparam int DEST_W      = 7;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 6;
  localparam int NUM_ENTRIES = 1 << ADDR_W;
  localparam int PACKIN_W    = 38;
  localparam int PACKOUT_W   = 52;

  // Field LSB positions in the incoming packet
  localparam int IN_DATA_LSB  = 0;
  localparam int IN_SEL_LSB   = 16;
  localparam int IN_Z_BIT     = 18;
  localparam int IN_C_BIT     = 19;
  localparam int IN_DEST_LSB  = 20;
  localparam int IN_GEN_LSB   = 27;
  localparam int IN_COLOR_LSB = 35;

  // Field LSB positions in the outgoing packet
  localparam int OUT_DATAR_LSB = 0;
  localparam int OUT_DATAL_LSB = 16;
  localparam int OUT_Z_BIT     = 32;
  localparam int OUT_C_BIT     = 33;
  localparam int OUT_DEST_LSB  = 34;
  localparam int OUT_GEN_LSB   = 41;
  localparam int OUT_COLOR_LSB = 49;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [GEN_W-1:0]   gen;
    logic [DEST_W-1:0]  dest;
    logic               c;
    logic               z;
    logic [1:0]         sel;
    logic [DATA_W-1:0]  data;
  } pkt_in_t;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [GEN_W-1:0]   gen;
    logic [DEST_W-1:0]  dest;
    logic               c;
    logic               z;
    logic [DATA_W-1:0]  data_l;
    logic [DATA_W-1:0]  data_r;
  } pkt_out_t;

endpackage

// File: rtl/mmram_mem.sv
// Operand store: one data word plus valid bit per entry, async-cleared,
// single write/clear port and a combinational read port.
`timescale 1ns/1ps
module mmram_mem
  import mmram_stage_pkg::*;
(
  input  logic              CLK,
  input  logic              MR_n,
  input  logic              i_wr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid
);

  logic [DATA_W-1:0]      r_data [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_valid;

  // Clear wins over write so a fetch-and-delete always leaves the entry empty
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_data[i] <= '0;
      r_valid <= '0;
    end else if (i_clr) begin
      r_data[i_waddr]  <= '0;
      r_valid[i_waddr] <= 1'b0;
    end else if (i_wr) begin
      r_data[i_waddr]  <= i_wdata;
      r_valid[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata  = r_data[i_raddr];
  assign o_rvalid = r_valid[i_raddr];

endmodule

// File: rtl/mmram_stage.sv
// Matching-memory pipeline stage: stores first operands, pairs them with the
// second arrival, or passes single-operand tokens straight through.
`timescale 1ns/1ps
module mmram_stage
  import mmram_stage_pkg::*;
(
  input  logic                 CLK,
  input  logic                 MR_n,
  input  logic                 Send_in,
  output logic                 Ack_out,
  input  logic [PACKIN_W-1:0]  PACKET_IN,
  input  logic                 WR_E,
  input  logic                 DEL,
  input  logic [ADDR_W-1:0]    ADDR,
  output logic                 Send_out,
  input  logic                 Ack_in,
  output logic [PACKOUT_W-1:0] PACKET_OUT
);

  pkt_in_t           w_in;
  pkt_out_t          w_next;
  logic              w_accept;
  logic              w_fire;
  logic              w_wr;
  logic              w_clr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_rvalid;
  logic [DATA_W-1:0] w_partner;
  logic              w_unused_sel0;

  logic              r_send_out;
  pkt_out_t          r_packet_out;

  assign w_in          = PACKET_IN;
  assign w_unused_sel0 = w_in.sel[0];

  assign Ack_out  = !r_send_out || Ack_in;
  assign w_accept = Send_in && Ack_out;
  assign w_fire   = w_accept && (DEL || !WR_E);
  assign w_wr     = w_accept && WR_E && !DEL;
  assign w_clr    = w_accept && DEL;

  mmram_mem u_mem (
    .CLK      (CLK),
    .MR_n     (MR_n),
    .i_wr     (w_wr),
    .i_clr    (w_clr),
    .i_waddr  (ADDR),
    .i_wdata  (w_in.data),
    .i_raddr  (ADDR),
    .o_rdata  (w_rdata),
    .o_rvalid (w_rvalid)
  );

  // Empty entries read as zero regardless of stale contents
  assign w_partner = w_rvalid ? w_rdata : '0;

  always_comb begin
    w_next.color  = w_in.color;
    w_next.gen    = w_in.gen;
    w_next.dest   = w_in.dest;
    w_next.c      = w_in.c;
    w_next.z      = w_in.z;
    w_next.data_l = w_in.data;
    w_next.data_r = '0;
    if (DEL) begin
      if (w_in.sel[1]) begin
        w_next.data_l = w_in.data;
        w_next.data_r = w_partner;
      end else begin
        w_next.data_l = w_partner;
        w_next.data_r = w_in.data;
      end
    end
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_send_out   <= 1'b0;
      r_packet_out <= '0;
    end else if (w_fire) begin
      r_send_out   <= 1'b1;
      r_packet_out <= w_next;
    end else if (Ack_in) begin
      r_send_out   <= 1'b0;
    end
  end

  assign Send_out   = r_send_out;
  assign PACKET_OUT = r_packet_out;

endmodule

// File: tb/tb_mmram_stage.sv
// Scoreboard bench for mmram_stage: expected pairs are queued at acceptance
// and compared when the stage hands them downstream.
`timescale 1ns/1ps
module tb_mmram_stage;

  logic        CLK;
  logic        MR_n;
  logic        Send_in;
  logic        Ack_out;
  logic [37:0] PACKET_IN;
  logic        WR_E;
  logic        DEL;
  logic [5:0]  ADDR;
  logic        Send_out;
  logic        Ack_in;
  logic [51:0] PACKET_OUT;

  int n_checks = 0;
  int n_errors = 0;

  logic [51:0] exp_q[$];
  logic [15:0] m_data[64];

  mmram_stage dut (
    .CLK        (CLK),
    .MR_n       (MR_n),
    .Send_in    (Send_in),
    .Ack_out    (Ack_out),
    .PACKET_IN  (PACKET_IN),
    .WR_E       (WR_E),
    .DEL        (DEL),
    .ADDR       (ADDR),
    .Send_out   (Send_out),
    .Ack_in     (Ack_in),
    .PACKET_OUT (PACKET_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [51:0] mk_out(input logic [2:0] color, input logic [7:0] gen,
                                         input logic [6:0] dest, input logic c, input logic z,
                                         input logic [15:0] dl, input logic [15:0] dr);
    return {color, gen, dest, c, z, dl, dr};
  endfunction

  // Consumer side: every downstream transfer must match the oldest expectation
  always @(negedge CLK) begin
    if (MR_n && Send_out && Ack_in) begin
      if (exp_q.size() == 0) begin
        chk("spurious_send", {63'd0, Send_out}, 64'd0);
      end else begin
        logic [51:0] e;
        e = exp_q.pop_front();
        chk("pkt_out", {12'd0, PACKET_OUT}, {12'd0, e});
        $display("OUT  pkt=%h exp=%h", PACKET_OUT, e);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic we, input logic del, input logic [5:0] addr,
                      input logic [2:0] color, input logic [7:0] gen, input logic [6:0] dest,
                      input logic c, input logic z, input logic [1:0] sel, input logic [15:0] data);
    int n;
    logic [15:0] partner;
    WR_E      = we;
    DEL       = del;
    ADDR      = addr;
    PACKET_IN = {color, gen, dest, c, z, sel, data};
    Send_in   = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!Ack_out && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!Ack_out) begin
      chk("accept_timeout", {63'd0, Ack_out}, 64'd1);
      Send_in = 1'b0;
      return;
    end
    @(posedge CLK);
    if (del) begin
      partner = m_data[addr];
      m_data[addr] = 16'h0;
      if (sel[1]) exp_q.push_back(mk_out(color, gen, dest, c, z, data, partner));
      else        exp_q.push_back(mk_out(color, gen, dest, c, z, partner, data));
    end else if (we) begin
      m_data[addr] = data;
    end else begin
      exp_q.push_back(mk_out(color, gen, dest, c, z, data, 16'h0));
    end
    $display("IN   we=%0b del=%0b addr=%0d sel=%b data=%h", we, del, addr, sel, data);
    #1;
    Send_in = 1'b0;
    WR_E    = 1'b0;
    DEL     = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [51:0] held;
    for (int i = 0; i < 64; i++) m_data[i] = 16'h0;
    MR_n = 1'b0; Send_in = 1'b0; PACKET_IN = '0; WR_E = 1'b0; DEL = 1'b0; ADDR = '0; Ack_in = 1'b1;

    // Reset held three cycles
    repeat (3) @(negedge CLK);
    chk("rst_send_out", {63'd0, Send_out}, 64'd0);
    chk("rst_packet_out", {12'd0, PACKET_OUT}, 64'd0);
    @(posedge CLK); #1;
    MR_n = 1'b1;
    @(negedge CLK);
    chk("rst_ack_out", {63'd0, Ack_out}, 64'd1);
    chk("rst_send_out_rel", {63'd0, Send_out}, 64'd0);
    @(posedge CLK); #1;
    send(0, 1, 6'd3, 3'd0, 8'd0, 7'd0, 0, 0, 2'b00, 16'h0040);
    drain();

    // Store then fetch at entry 3
    send(1, 0, 6'd3, 3'd0, 8'd0, 7'd0, 0, 0, 2'b11, 16'h0055);
    @(negedge CLK);
    chk("wr_no_send", {63'd0, Send_out}, 64'd0);
    @(posedge CLK); #1;
    send(0, 1, 6'd3, 3'd0, 8'd0, 7'd4, 1, 1, 2'b00, 16'h0040);
    @(negedge CLK);
    chk("del_latency", {63'd0, Send_out}, 64'd1);
    @(posedge CLK); #1;
    send(0, 1, 6'd3, 3'd1, 8'd2, 7'd3, 0, 1, 2'b00, 16'h0001);
    drain();

    // Left/right swap
    send(1, 0, 6'd5, 3'd0, 8'd0, 7'd0, 0, 0, 2'b00, 16'h0007);
    send(0, 1, 6'd5, 3'd2, 8'd17, 7'd9, 0, 1, 2'b11, 16'h0078);
    drain();

    // Pass-through leaves memory alone; SEL[0] has no effect
    send(0, 0, 6'd0, 3'd5, 8'hA5, 7'd33, 1, 0, 2'b10, 16'h0040);
    send(0, 0, 6'd1, 3'd6, 8'h5A, 7'd34, 0, 1, 2'b01, 16'h0041);
    drain();
    chk("pass_mem_untouched", dut.u_mem.r_valid, 64'd0);

    // Backpressure holds the token
    Ack_in = 1'b0;
    send(0, 0, 6'd2, 3'd7, 8'h11, 7'd9, 1, 1, 2'b00, 16'h1234);
    held = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_send_out", {63'd0, Send_out}, 64'd1);
      chk("bp_ack_out", {63'd0, Ack_out}, 64'd0);
      chk("bp_stable", {12'd0, PACKET_OUT}, {12'd0, held});
    end
    @(posedge CLK); #1;
    Ack_in = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_drained_send", {63'd0, Send_out}, 64'd0);
    chk("bp_drained_ack", {63'd0, Ack_out}, 64'd1);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge CLK); #1;

    // Interleaved stores and fetches, one per cycle
    send(1, 0, 6'd3, 3'd0, 8'd0, 7'd0, 0, 0, 2'b00, 16'h00A3);
    send(1, 0, 6'd4, 3'd0, 8'd0, 7'd0, 0, 0, 2'b00, 16'h00A4);
    send(1, 0, 6'd5, 3'd0, 8'd0, 7'd0, 0, 0, 2'b00, 16'h00A5);
    chk("il_valid_set", dut.u_mem.r_valid, 64'h38);
    send(0, 1, 6'd5, 3'd1, 8'd1, 7'd5, 1, 0, 2'b00, 16'h0010);
    send(0, 1, 6'd4, 3'd1, 8'd1, 7'd4, 0, 1, 2'b00, 16'h0020);
    send(0, 1, 6'd3, 3'd1, 8'd1, 7'd3, 1, 1, 2'b00, 16'h0030);
    drain();
    chk("il_valid_clear", dut.u_mem.r_valid, 64'd0);

    // Reset mid-operation drops the pending token and stored operands
    send(1, 0, 6'd7, 3'd0, 8'd0, 7'd0, 0, 0, 2'b00, 16'h0099);
    Ack_in = 1'b0;
    send(0, 0, 6'd8, 3'd3, 8'd3, 7'd3, 0, 0, 2'b00, 16'hBEEF);
    @(negedge CLK); #1;
    MR_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) m_data[i] = 16'h0;
    #1;
    chk("mid_rst_send", {63'd0, Send_out}, 64'd0);
    chk("mid_rst_pkt", {12'd0, PACKET_OUT}, 64'd0);
    chk("mid_rst_valid", dut.u_mem.r_valid, 64'd0);
    @(posedge CLK); #1;
    MR_n = 1'b1;
    Ack_in = 1'b1;
    send(0, 1, 6'd7, 3'd4, 8'd4, 7'd7, 0, 0, 2'b10, 16'h0005);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
